// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_sequencer
//  Description : Address/strobe sequencer for an N x N matrix multiply
//                C = A * B. Issues operand reads in i/j/k order, pipelines
//                the MAC enable, accumulator clear and result write strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module matmul_sequencer #(
  parameter int N_LOG2     = 2,
  parameter int START_HOLD = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [2*N_LOG2-1:0]   a_addr,
  output logic [2*N_LOG2-1:0]   b_addr,
  output logic                  acc_clr,
  output logic                  mac_en,
  output logic                  c_we,
  output logic [2*N_LOG2-1:0]   c_addr,
  output logic [1:0]            status,
  output logic                  done
);

  localparam int                  c_AW        = 2 * N_LOG2;
  localparam int                  c_HOLD_W    = 10;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(START_HOLD - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [N_LOG2-1:0]   r_i;
  logic [N_LOG2-1:0]   r_j;
  logic [N_LOG2-1:0]   r_k;
  logic                r_drain_cnt;
  logic                r_mac_en;
  logic                r_acc_clr;
  logic                r_wb_pend;
  logic [c_AW-1:0]     r_wb_addr;
  logic                r_c_we;
  logic [c_AW-1:0]     r_c_addr;
  logic                r_done;

  logic                w_launch;
  logic                w_last_issue;
  logic                w_rd_en;
  logic                w_k_last;

  // Launch fires on the edge that sees start high for the START_HOLD-th time
  assign w_launch     = (r_state == c_IDLE) && start && !abort && (r_hold_cnt == c_HOLD_LAST);
  assign w_k_last     = &r_k;
  assign w_last_issue = w_k_last && (&r_j) && (&r_i);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_launch) begin
          w_next_state = c_RUN;
        end
      end
      c_RUN: begin
        if (abort) begin
          w_next_state = c_IDLE;
        end else if (w_last_issue) begin
          w_next_state = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (abort) begin
          w_next_state = c_IDLE;
        end else if (r_drain_cnt) begin
          w_next_state = c_DONE;
        end
      end
      default: begin
        if (abort || !start) begin
          w_next_state = c_IDLE;
        end
      end
    endcase
  end

  // Output decode from state; addresses are plain index concatenations
  always_comb begin
    status  = 2'b00;
    w_rd_en = 1'b0;
    case (r_state)
      c_RUN: begin
        status  = 2'b01;
        w_rd_en = 1'b1;
      end
      c_DRAIN: status = 2'b01;
      c_DONE:  status = 2'b11;
      default: status = 2'b00;
    endcase
  end

  assign rd_en   = w_rd_en;
  assign a_addr  = {r_i, r_k};
  assign b_addr  = {r_k, r_j};
  assign mac_en  = r_mac_en;
  assign acc_clr = r_acc_clr;
  assign c_we    = r_c_we;
  assign c_addr  = r_c_addr;
  assign done    = r_done;

  // Start-hold counter: counts consecutive high samples in IDLE, restarts on launch
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == c_IDLE) begin
      if (abort || !start || w_launch) begin
        r_hold_cnt <= '0;
      end else begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  // Loop indices: k innermost, then j, then i; frozen on the final issue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (w_launch) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if ((r_state == c_RUN) && !abort && !w_last_issue) begin
      r_k <= r_k + 1'b1;
      if (w_k_last) begin
        r_j <= r_j + 1'b1;
        if (&r_j) begin
          r_i <= r_i + 1'b1;
        end
      end
    end
  end

  // Drain timer: two cycles to let the last MAC and write retire
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_drain_cnt <= 1'b0;
    end else if (r_state == c_DRAIN) begin
      r_drain_cnt <= ~r_drain_cnt;
    end else begin
      r_drain_cnt <= 1'b0;
    end
  end

  // Strobe pipeline: MAC one cycle after issue, write two cycles after k=N-1 issue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mac_en  <= 1'b0;
      r_acc_clr <= 1'b0;
      r_wb_pend <= 1'b0;
      r_wb_addr <= '0;
      r_c_we    <= 1'b0;
      r_c_addr  <= '0;
    end else begin
      r_mac_en  <= w_rd_en && !abort;
      r_acc_clr <= w_rd_en && !abort && (r_k == '0);
      r_wb_pend <= w_rd_en && !abort && w_k_last;
      if (w_rd_en && w_k_last) begin
        r_wb_addr <= {r_i, r_j};
      end
      r_c_we <= r_wb_pend && !abort;
      if (r_wb_pend && !abort) begin
        r_c_addr <= r_wb_addr;
      end
    end
  end

  // Done pulse on the DRAIN->DONE transition only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == c_DRAIN) && r_drain_cnt && !abort;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_sequencer
//  Description : Bench for matmul_sequencer. Operand memories and an
//                accumulator are modelled around the DUT; expected C writes
//                come from a plain matrix product and are queued per run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_matmul_sequencer;

  localparam int N_LOG2     = 2;
  localparam int N          = 1 << N_LOG2;
  localparam int NN         = N * N;
  localparam int START_HOLD = 10;
  localparam int AW         = 2 * N_LOG2;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          acc_clr;
  logic          mac_en;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [1:0]    status;
  logic          done;

  matmul_sequencer #(
    .N_LOG2     (N_LOG2),
    .START_HOLD (START_HOLD)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .rd_en   (rd_en),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .acc_clr (acc_clr),
    .mac_en  (mac_en),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .status  (status),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int     addr;
    longint val;
  } wr_t;

  wr_t    sb_q[$];
  int     n_total = 0;
  int     n_pass  = 0;
  int     mem_a [0:NN-1];
  int     mem_b [0:NN-1];

  // Monitor-side model state
  longint acc      = 0;
  int     pend_a   = 0;
  int     pend_b   = 0;
  logic   prev_rd  = 1'b0;
  logic   prev_k0  = 1'b0;
  logic   abort_smp = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected writes of a run: the first n_elems elements of C = A*B in row-major order
  task automatic push_run(input int n_elems);
    wr_t w;
    for (int e = 0; e < n_elems; e++) begin
      w.addr = e;
      w.val  = 0;
      for (int kk = 0; kk < N; kk++)
        w.val += longint'(mem_a[(e / N) * N + kk]) * longint'(mem_b[kk * N + (e % N)]);
      sb_q.push_back(w);
    end
  endtask

  task automatic randomize_mems();
    for (int e = 0; e < NN; e++) begin
      mem_a[e] = int'($urandom_range(0, 255));
      mem_b[e] = int'($urandom_range(0, 255));
    end
  endtask

  // Called at a negedge with the DUT idle and the hold count at zero
  task automatic launch(input string name);
    start = 1'b1;
    repeat (START_HOLD - 1) @(negedge clock);
    check({name, "_pre_launch_status"}, status, 0);
    @(negedge clock);
    check({name, "_entry_status"}, status, 1);
  endtask

  // Called on the first RUN cycle; follows the run until DONE
  task automatic run_to_done(input string name);
    int cnt, rd_cnt, bad;
    cnt = 1; rd_cnt = 0; bad = 0;
    while (status != 2'b11 && cnt < 200) begin
      if (rd_en) rd_cnt++;
      if (status != 2'b01 || done) bad++;
      @(negedge clock);
      cnt++;
    end
    check({name, "_no_timeout"}, (cnt < 200), 1);
    check({name, "_rd_cycles"}, rd_cnt, N * N * N);
    check({name, "_process_status"}, bad, 0);
    // done rises on the 66th edge after RUN entry, seen at the 67th RUN-relative sample
    check({name, "_done_cycle"}, cnt, N * N * N + 3);
    check({name, "_done_pulse"}, done, 1);
    check({name, "_writes_left"}, sb_q.size(), 0);
  endtask

  // abort as seen by the DUT at the last rising edge
  always @(posedge clock) abort_smp = abort;

  // Monitor: checks strobe alignment, models the datapath and scores C writes
  always @(negedge clock) begin
    wr_t w;
    if (!reset_n) begin
      acc = 0; pend_a = 0; pend_b = 0; prev_rd = 1'b0; prev_k0 = 1'b0;
    end else begin
      if (c_we) begin
        if (sb_q.size() == 0) begin
          check("c_we_unexpected", 1, 0);
        end else begin
          w = sb_q.pop_front();
          check("c_addr", c_addr, w.addr);
          check("c_value", acc, w.val);
        end
      end
      check("mac_en_acc_clr_align", {mac_en, acc_clr},
            {prev_rd && !abort_smp, prev_k0 && !abort_smp});
      check("status_not_10", (status == 2'b10), 0);
      if (rd_en || mac_en || c_we) check("strobe_in_process", status, 1);
      if (mac_en) begin
        if (acc_clr) acc = longint'(pend_a) * longint'(pend_b);
        else         acc = acc + longint'(pend_a) * longint'(pend_b);
      end
      prev_rd = rd_en;
      prev_k0 = rd_en && (a_addr[N_LOG2-1:0] == '0);
      if (rd_en) begin
        pend_a = mem_a[a_addr];
        pend_b = mem_b[b_addr];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    start = 1'b0; abort = 1'b0; reset_n = 1'b0;
    for (int e = 0; e < NN; e++) begin mem_a[e] = 0; mem_b[e] = 0; end
    repeat (2) @(negedge clock);
    check("reset_outputs", {status, rd_en, mac_en, acc_clr, c_we, done, a_addr, b_addr, c_addr}, 0);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // Run 1: A = identity, B = 0..15, so C must equal B
    for (int e = 0; e < NN; e++) begin
      mem_a[e] = ((e / N) == (e % N)) ? 1 : 0;
      mem_b[e] = e;
    end
    push_run(NN);
    launch("run1");
    run_to_done("run1");
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (status != 2'b11 || done) bad++;
    end
    check("done_hold_with_start", bad, 0);
    start = 1'b0;
    @(negedge clock);
    check("done_exit_to_idle", status, 0);

    // 9 high, 1 low must not launch; a fresh run of 10 then does
    bad = 0;
    start = 1'b1;
    repeat (9) begin
      @(negedge clock);
      if (rd_en || status != 2'b00) bad++;
    end
    start = 1'b0;
    @(negedge clock);
    if (rd_en || status != 2'b00) bad++;
    check("burst9_no_launch", bad, 0);

    // Abort at RUN cycle 30: writes at cycles N*(e+1)+2 <= 30 survive
    randomize_mems();
    begin
      int n_keep;
      n_keep = 0;
      for (int e = 0; e < NN; e++) if (N * (e + 1) + 2 <= 30) n_keep++;
      push_run(n_keep);
    end
    launch("abort_run");
    repeat (29) @(negedge clock);
    check("abort_pre_status", status, 1);
    abort = 1'b1;
    start = 1'b0;
    @(negedge clock);
    check("abort_status", status, 0);
    check("abort_strobes", {rd_en, mac_en, acc_clr, c_we}, 0);
    abort = 1'b0;
    repeat (8) @(negedge clock);
    check("abort_writes_left", sb_q.size(), 0);
    check("abort_stays_idle", status, 0);

    // Asynchronous reset in RUN cycle 20: writes at cycles <= 20 are observed
    randomize_mems();
    begin
      int n_keep;
      n_keep = 0;
      for (int e = 0; e < NN; e++) if (N * (e + 1) + 2 <= 20) n_keep++;
      push_run(n_keep);
    end
    launch("reset_run");
    repeat (19) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs",
             {status, rd_en, mac_en, acc_clr, c_we, done, a_addr, b_addr, c_addr}, 0);
    repeat (2) @(negedge clock);
    check("reset_writes_left", sb_q.size(), 0);
    #2 reset_n = 1'b1;

    // Relaunch with start still high needs a full fresh hold
    randomize_mems();
    push_run(NN);
    launch("relaunch");
    run_to_done("relaunch");
    start = 1'b0;
    @(negedge clock);
    check("final_idle", status, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
